// File: rtl/prng_pkg.sv
// Shared definitions for the prng scheduler: default widths, FSM state encoding and a clog2 helper.
package prng_pkg;

   localparam int unsigned LFSR_SIZE_DEF = 43;
   localparam int unsigned OUT_SIZE_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      WARMUP = 2'd2,
      SERVE  = 2'd3
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prng_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index; the pointer moves only on advance.
module rr_arbiter
   import prng_pkg::*;
#(
   parameter int unsigned N_REQ = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic             advance,
   output logic [N_REQ-1:0] winner
);

   localparam int unsigned PW = clog2(N_REQ);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    idx;
   logic [PW-1:0]    next_ptr;
   logic [N_REQ-1:0] elig;
   logic             found;

   always_comb begin
      elig     = req & ~mask;
      winner   = '0;
      idx      = '0;
      next_ptr = ptr_q;
      found    = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = PW'((32'(ptr_q) + i) % N_REQ);
         if (!found && elig[idx]) begin
            found       = 1'b1;
            winner[idx] = 1'b1;
            next_ptr    = PW'((32'(idx) + 1) % N_REQ);
         end
      end
   end

   // Kept apart from the search so advance (derived from winner) forms no combinational cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) ptr_d = next_ptr;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/prng_scheduler.sv
// Sequences seeding and warm-up of the shared prng, then hands one sample per cycle to
// round-robin selected requesters through a two-stage fetch/deliver pipeline.
module prng_scheduler
   import prng_pkg::*;
#(
   parameter int unsigned LFSR_SIZE     = LFSR_SIZE_DEF,
   parameter int unsigned OUT_SIZE      = OUT_SIZE_DEF,
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned WARMUP_CYCLES = 64,
   parameter int unsigned CNT_W         = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [LFSR_SIZE-1:0] seed_in,
   input  logic                 reseed,
   input  logic [N_REQ-1:0]     req,
   output logic [N_REQ-1:0]     gnt,
   output logic                 rnd_valid,
   output logic [OUT_SIZE-1:0]  rnd_data,
   output logic                 ready,
   output logic [CNT_W-1:0]     sample_count,
   output logic [LFSR_SIZE-1:0] prng_seed,
   output logic                 prng_reset,
   output logic                 prng_enable,
   output logic                 prng_fetch,
   input  logic [OUT_SIZE-1:0]  prng_data
);

   localparam int unsigned WC_W = clog2(WARMUP_CYCLES + 1);

   state_e               state_q, state_d;
   logic [LFSR_SIZE-1:0] seed_q, seed_d;
   logic [WC_W-1:0]      wcnt_q, wcnt_d;
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [N_REQ-1:0]     win;
   logic                 serve_fetch;

   // The index delivered this cycle is masked so a held req is not fetched twice.
   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .mask    (gnt_q),
      .advance (serve_fetch),
      .winner  (win)
   );

   assign serve_fetch = (state_q == SERVE) && !reseed && (|win);

   always_comb begin
      state_d = state_q;
      seed_d  = seed_q;
      wcnt_d  = wcnt_q;
      ready_d = ready_q;
      valid_d = serve_fetch;
      gnt_d   = serve_fetch ? win : '0;
      count_d = serve_fetch ? count_q + CNT_W'(1) : count_q;
      if (reseed) seed_d = (seed_in == '0) ? LFSR_SIZE'(1) : seed_in;
      case (state_q)
         IDLE:    if (reseed) state_d = SEED;
         SEED: begin
            wcnt_d  = '0;
            state_d = reseed ? SEED : WARMUP;
         end
         WARMUP: begin
            if (reseed) begin
               state_d = SEED;
            end else if (wcnt_q == WC_W'(WARMUP_CYCLES - 1)) begin
               state_d = SERVE;
               ready_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WC_W'(1);
            end
         end
         SERVE: begin
            if (reseed) begin
               state_d = SEED;
               ready_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         seed_q  <= '0;
         wcnt_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         gnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         seed_q  <= seed_d;
         wcnt_q  <= wcnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         gnt_q   <= gnt_d;
         count_q <= count_d;
      end
   end

   assign gnt          = gnt_q;
   assign rnd_valid    = valid_q;
   assign rnd_data     = valid_q ? prng_data : '0;
   assign ready        = ready_q;
   assign sample_count = count_q;
   assign prng_seed    = seed_q;
   assign prng_reset   = (state_q == SEED);
   assign prng_enable  = (state_q == WARMUP) || serve_fetch;
   assign prng_fetch   = (state_q == WARMUP) || serve_fetch;

endmodule

// File: tb/tb_prng_scheduler.sv
// Directed bench for prng_scheduler with a behavioural prng model; a CNT_W=4 twin checks counter wrap.
module tb_prng_scheduler;

   localparam int unsigned W = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic [42:0] seed_in;
   logic        reseed;
   logic [3:0]  req;
   logic [3:0]  gnt;
   logic        rnd_valid;
   logic [31:0] rnd_data;
   logic        ready;
   logic [31:0] sample_count;
   logic [42:0] prng_seed;
   logic        prng_reset, prng_enable, prng_fetch;
   logic [31:0] prng_data;

   logic [3:0]  gnt_b;
   logic        rnd_valid_b, ready_b;
   logic [31:0] rnd_data_b;
   logic [3:0]  sample_count_b;
   logic [42:0] prng_seed_b;
   logic        prng_reset_b, prng_enable_b, prng_fetch_b;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned exp_cnt = 0;
   int unsigned base, adv0;
   int unsigned per [4];
   logic [42:0] lfsr0;
   logic [42:0] s1, s2, s3;

   logic [42:0] m_lfsr = '0;
   logic [31:0] m_data = '0;
   int unsigned m_adv = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (prng_reset) begin
         m_lfsr <= prng_seed;
         m_data <= '0;
      end else if (prng_enable && prng_fetch) begin
         m_lfsr <= {m_lfsr[41:0], m_lfsr[42] ^ m_lfsr[41] ^ m_lfsr[37] ^ m_lfsr[36]};
         m_data <= m_lfsr[31:0] ^ m_lfsr[42:11];
         m_adv  <= m_adv + 1;
      end
   end
   assign prng_data = m_data;

   prng_scheduler #(.LFSR_SIZE(43), .OUT_SIZE(32), .N_REQ(4), .WARMUP_CYCLES(W), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .seed_in(seed_in), .reseed(reseed), .req(req),
      .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .ready(ready),
      .sample_count(sample_count), .prng_seed(prng_seed), .prng_reset(prng_reset),
      .prng_enable(prng_enable), .prng_fetch(prng_fetch), .prng_data(prng_data)
   );

   prng_scheduler #(.LFSR_SIZE(43), .OUT_SIZE(32), .N_REQ(4), .WARMUP_CYCLES(W), .CNT_W(4)) dut_b (
      .clock(clock), .reset(reset), .seed_in(seed_in), .reseed(reseed), .req(req),
      .gnt(gnt_b), .rnd_valid(rnd_valid_b), .rnd_data(rnd_data_b), .ready(ready_b),
      .sample_count(sample_count_b), .prng_seed(prng_seed_b), .prng_reset(prng_reset_b),
      .prng_enable(prng_enable_b), .prng_fetch(prng_fetch_b), .prng_data(prng_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, 64'(gnt), 64'd0);
      chk({tag, "_valid"}, 64'(rnd_valid), 64'd0);
      chk({tag, "_data"}, 64'(rnd_data), 64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd0);
      chk({tag, "_count"}, 64'(sample_count), 64'd0);
      chk({tag, "_count_b"}, 64'(sample_count_b), 64'd0);
      chk({tag, "_preset"}, 64'(prng_reset), 64'd0);
      chk({tag, "_penable"}, 64'(prng_enable), 64'd0);
      chk({tag, "_pfetch"}, 64'(prng_fetch), 64'd0);
      chk({tag, "_pseed"}, 64'(prng_seed), 64'd0);
   endtask

   initial begin
      reset = 1'b0; reseed = 1'b0; req = '0; seed_in = '0;
      s1 = 43'h123_4567_89AB; s2 = 43'h0F0_F0F0_F0F0; s3 = 43'h5;
      cyc(); cyc();
      chk_reset_vals("rst");
      @(negedge clock) reset = 1'b1;
      cyc();
      req = 4'b1111; #1;
      chk("idle_ignore_req", 64'(prng_fetch), 64'd0);
      req = '0;

      // Test 1: zero seed guard and warm-up length
      reseed = 1'b1; seed_in = '0;
      cyc();
      reseed = 1'b0;
      chk("seed_zero_guard", 64'(prng_seed), 64'd1);
      chk("seed_preset", 64'(prng_reset), 64'd1);
      for (int k = 0; k < W; k++) begin
         cyc();
         chk("warmup_ready", 64'(ready), 64'd0);
         chk("warmup_valid", 64'(rnd_valid), 64'd0);
         chk("warmup_enable", 64'(prng_enable), 64'd1);
      end
      cyc();
      chk("ready_rise", 64'(ready), 64'd1);
      chk("serve_idle_fetch", 64'(prng_fetch), 64'd0);
      chk("warmup_discards", 64'(m_adv), 64'(W));

      // Test 2: single requester gets one sample every other cycle
      req = 4'b0001; #1;
      chk("t2_fetch", 64'(prng_fetch), 64'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_cnt++;
         chk("t2_valid", 64'(rnd_valid), 64'd1);
         chk("t2_gnt", 64'(gnt), 64'b0001);
         chk("t2_data", 64'(rnd_data), 64'(m_data));
         chk("t2_count", 64'(sample_count), 64'(exp_cnt));
         chk("t2_masked", 64'(prng_fetch), 64'd0);
         if (i < 3) begin
            cyc();
            chk("t2_gap_valid", 64'(rnd_valid), 64'd0);
            chk("t2_gap_data", 64'(rnd_data), 64'd0);
            chk("t2_gap_fetch", 64'(prng_fetch), 64'd1);
         end
      end
      req = '0;
      cyc();
      chk("t2_drop", 64'(rnd_valid), 64'd0);

      req = 4'b1000;
      cyc();
      exp_cnt++;
      chk("ptr_wrap_gnt", 64'(gnt), 64'b1000);
      req = '0;
      cyc();

      // Test 3: all four requesting, strict rotation
      base = exp_cnt;
      for (int b = 0; b < 4; b++) per[b] = 0;
      req = 4'b1111;
      for (int i = 0; i < 400; i++) begin
         cyc();
         exp_cnt++;
         chk("t3_valid", 64'(rnd_valid), 64'd1);
         chk("t3_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
         chk("t3_data", 64'(rnd_data), 64'(m_data));
         for (int b = 0; b < 4; b++) if (gnt[b] && rnd_valid) per[b]++;
      end
      req = '0;
      chk("t3_count", 64'(sample_count), 64'(exp_cnt));
      chk("t3_count_delta", 64'(sample_count - base), 64'd400);
      for (int b = 0; b < 4; b++) chk("t3_fair", 64'(per[b]), 64'd100);
      chk("t3_count_wrap4", 64'(sample_count_b), 64'(exp_cnt % 16));
      cyc();
      chk("t3_stop", 64'(rnd_valid), 64'd0);

      // Test 4: sparse requesters alternate, idle holds the prng
      req = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         cyc();
         exp_cnt++;
         chk("t4_gnt", 64'(gnt), (i % 2 == 0) ? 64'b0001 : 64'b0100);
         chk("t4_data", 64'(rnd_data), 64'(m_data));
      end
      req = '0;
      adv0 = m_adv; lfsr0 = m_lfsr;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t4_idle_fetch", 64'(prng_fetch), 64'd0);
         chk("t4_idle_valid", 64'(rnd_valid), 64'd0);
      end
      chk("t4_prng_hold_adv", 64'(m_adv), 64'(adv0));
      chk("t4_prng_hold_state", 64'(m_lfsr), 64'(lfsr0));

      // Test 5: reseed in SERVE, during SEED, and mid warm-up
      req = 4'b0011;
      cyc();
      exp_cnt++;
      chk("t5_inflight_gnt", 64'(gnt), 64'b0001);
      chk("t5_inflight_data", 64'(rnd_data), 64'(m_data));
      reseed = 1'b1; seed_in = s1; #1;
      chk("t5_reseed_wins", 64'(prng_fetch), 64'd0);
      cyc();
      reseed = 1'b0; req = '0;
      chk("t5_ready_drop", 64'(ready), 64'd0);
      chk("t5_no_valid", 64'(rnd_valid), 64'd0);
      chk("t5_seed_state", 64'(prng_reset), 64'd1);
      chk("t5_seed_val", 64'(prng_seed), 64'(s1));
      chk("t5_count", 64'(sample_count), 64'(exp_cnt));
      reseed = 1'b1; seed_in = s2;
      cyc();
      reseed = 1'b0;
      chk("t5_seed_repeat", 64'(prng_reset), 64'd1);
      chk("t5_seed_recapture", 64'(prng_seed), 64'(s2));
      for (int k = 0; k < 30; k++) begin
         cyc();
         chk("t5_warm_a", 64'(ready), 64'd0);
      end
      reseed = 1'b1; seed_in = s3;
      cyc();
      reseed = 1'b0;
      chk("t5_warm_reseed", 64'(prng_reset), 64'd1);
      chk("t5_warm_seed", 64'(prng_seed), 64'(s3));
      adv0 = m_adv;
      for (int k = 0; k < W; k++) begin
         cyc();
         chk("t5_warm_b", 64'(ready), 64'd0);
      end
      cyc();
      chk("t5_ready_again", 64'(ready), 64'd1);
      chk("t5_full_warmup", 64'(m_adv - adv0), 64'(W));

      // Test 6: asynchronous reset mid-serve, then counter wrap on the narrow twin
      req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         exp_cnt++;
         chk("t6_gnt", 64'(gnt), 64'(4'b0001 << ((1 + i) % 4)));
      end
      #1 reset = 1'b0;
      #1;
      chk_reset_vals("t6_async");
      exp_cnt = 0;
      req = '0;
      @(negedge clock) reset = 1'b1;
      cyc();
      reseed = 1'b1; seed_in = 43'h5;
      cyc();
      reseed = 1'b0;
      for (int k = 0; k < W; k++) cyc();
      cyc();
      chk("t6_ready", 64'(ready), 64'd1);
      req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         cyc();
         exp_cnt++;
         chk("t6_rr_from_zero", 64'(gnt), 64'(4'b0001 << (i % 4)));
      end
      req = '0;
      chk("t6_count", 64'(sample_count), 64'd20);
      chk("t6_count_wrap", 64'(sample_count_b), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
